intr_ctl: RTL and testbench

- Interrupt controller and system-register file for the 16-bit pipelined core.
- Arbitrates the device interrupt lines (timer, keys, switches) by fixed priority and requests the pipeline to take an interrupt at an instruction boundary.
- On acknowledge, saves the return PC and cause, then manages IE/OIE/CM/OM.
- Serves RSR/WSR access and RETI restore, replacing the ad-hoc system registers in the core's top level.

---
 rtl/intr_ctl_pkg.sv | 32 +++
 rtl/intr_prio_enc.sv | 21 ++
 rtl/intr_ctl.sv | 192 +++++++++++++++++++
 tb/tb_intr_ctl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/intr_ctl_pkg.sv
// Shared definitions for the interrupt controller: system register numbers,
// SCS bit positions, the unmapped-register read pattern and the FSM encoding.
// Optional feature macro used by this slice: INTR_MASK_EN (per-source enable in sysreg 4).
package intr_ctl_pkg;

  // System register numbers as seen by RSR/WSR
  localparam logic [2:0] SREG_SCS  = 3'd0;
  localparam logic [2:0] SREG_SIH  = 3'd1;
  localparam logic [2:0] SREG_SRA  = 3'd2;
  localparam logic [2:0] SREG_SII  = 3'd3;
  localparam logic [2:0] SREG_SIM  = 3'd4;
  localparam logic [2:0] SREG_RSV5 = 3'd5;
  localparam logic [2:0] SREG_SR0  = 3'd6;
  localparam logic [2:0] SREG_SR1  = 3'd7;

  // Bit positions inside SCS = {OM,CM,OIE,IE}
  localparam int SCS_IE  = 0;
  localparam int SCS_OIE = 1;
  localparam int SCS_CM  = 2;
  localparam int SCS_OM  = 3;

  // Read value for unimplemented register slots
  localparam logic [15:0] SREG_FILL = 16'hFAFA;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HOLD = 2'd2
  } intr_state_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
// Purely combinational, no state; index 0 has the highest priority.
module intr_prio_enc #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  // Scan from the top so the lowest set index is the last assignment and wins
  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/intr_ctl.sv
// Interrupt controller and system-register file for the 16-bit pipelined core.
// IRQ rises one cycle after a qualifying INTR; RSR reads are combinational, WSR lands at the edge.
// Optional macro INTR_MASK_EN adds the per-source enable register SIM at sysreg 4.
module intr_ctl
  import intr_ctl_pkg::*;
#(
  parameter int               DBITS     = 16,
  parameter int               NSRC      = 3,
  parameter logic [DBITS-1:0] SIH_RESET = 'h0010,
  parameter int               HOLDOFF   = 2,
  parameter int               CBITS     = 2
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic [NSRC-1:0]  INTR,
  output logic             IRQ,
  input  logic             IRQ_ACK,
  input  logic [DBITS-1:0] RET_PC,
  output logic [DBITS-1:0] HANDLER,
  input  logic             RETI,
  output logic [DBITS-1:0] RETI_PC,
  input  logic [2:0]       SRNO,
  output logic [DBITS-1:0] SRRD,
  input  logic             SRWE,
  input  logic [DBITS-1:0] SRWD,
  output logic [3:0]       SCS
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  // Counter load on RETI; a HOLDOFF of 0 bypasses HOLD entirely
  localparam logic [CBITS-1:0] HOLD_LOAD = CBITS'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  intr_state_e      state_q;
  logic             irq_q;
  logic [IW-1:0]    win_q;
  logic [CBITS-1:0] cnt_q;

  logic [3:0]       scs_q,  scs_d;
  logic [DBITS-1:0] sih_q,  sih_d;
  logic [DBITS-1:0] sra_q,  sra_d;
  logic [DBITS-1:0] sii_q,  sii_d;
  logic [DBITS-1:0] sr0_q,  sr0_d;
  logic [DBITS-1:0] sr1_q,  sr1_d;

  logic [NSRC-1:0]  req;
  logic             req_vld;
  logic [IW-1:0]    req_idx;
  logic             ack_take;
  logic             reti_take;

`ifdef INTR_MASK_EN
  logic [NSRC-1:0]  sim_q, sim_d;
  assign req = INTR & sim_q;
`else
  assign req = INTR;
`endif

  intr_prio_enc #(.N(NSRC), .IW(IW)) u_prio (
    .req_i (req),
    .vld_o (req_vld),
    .idx_o (req_idx)
  );

  // An acknowledge only counts while a request is outstanding, and it shadows a same-cycle RETI
  assign ack_take  = (state_q == PEND) && IRQ_ACK;
  assign reti_take = RETI && !ack_take;

  // Next-state of the system registers: software write first, then entry/return updates override
  always_comb begin
    scs_d = scs_q;
    sih_d = sih_q;
    sra_d = sra_q;
    sii_d = sii_q;
    sr0_d = sr0_q;
    sr1_d = sr1_q;
`ifdef INTR_MASK_EN
    sim_d = sim_q;
`endif
    if (SRWE) begin
      case (SRNO)
        SREG_SCS: scs_d = SRWD[3:0];
        SREG_SIH: sih_d = SRWD;
        SREG_SRA: sra_d = SRWD;
        SREG_SII: sii_d = SRWD;
`ifdef INTR_MASK_EN
        SREG_SIM: sim_d = SRWD[NSRC-1:0];
`endif
        SREG_SR0: sr0_d = SRWD;
        SREG_SR1: sr1_d = SRWD;
        default: ;
      endcase
    end
    if (ack_take) begin
      sra_d          = RET_PC;
      sii_d          = DBITS'(win_q);
      scs_d[SCS_OIE] = scs_q[SCS_IE];
      scs_d[SCS_IE]  = 1'b0;
      scs_d[SCS_OM]  = scs_q[SCS_CM];
      scs_d[SCS_CM]  = 1'b1;
    end else if (reti_take) begin
      scs_d[SCS_IE]  = scs_q[SCS_OIE];
      scs_d[SCS_CM]  = scs_q[SCS_OM];
    end
  end

  // System register storage
  always_ff @(posedge CLK) begin
    if (INIT) begin
      scs_q <= '0;
      sih_q <= SIH_RESET;
      sra_q <= '0;
      sii_q <= '0;
      sr0_q <= '0;
      sr1_q <= '0;
`ifdef INTR_MASK_EN
      sim_q <= '1;
`endif
    end else begin
      scs_q <= scs_d;
      sih_q <= sih_d;
      sra_q <= sra_d;
      sii_q <= sii_d;
      sr0_q <= sr0_d;
      sr1_q <= sr1_d;
`ifdef INTR_MASK_EN
      sim_q <= sim_d;
`endif
    end
  end

  // Request FSM: arbitrate in IDLE, hold the winner in PEND, block new requests in HOLD after RETI
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else if (reti_take) begin
      irq_q   <= 1'b0;
      cnt_q   <= HOLD_LOAD;
      state_q <= (HOLDOFF == 0) ? IDLE : HOLD;
    end else begin
      case (state_q)
        IDLE: begin
          if (scs_q[SCS_IE] && req_vld) begin
            win_q   <= req_idx;
            irq_q   <= 1'b1;
            state_q <= PEND;
          end
        end
        PEND: begin
          // A WSR clearing IE withdraws the request at the same edge it lands
          if (IRQ_ACK || !scs_d[SCS_IE]) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CBITS'(1);
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Combinational RSR read mux
  always_comb begin
    SRRD = DBITS'(SREG_FILL);
    case (SRNO)
      SREG_SCS: SRRD = DBITS'(scs_q);
      SREG_SIH: SRRD = sih_q;
      SREG_SRA: SRRD = sra_q;
      SREG_SII: SRRD = sii_q;
`ifdef INTR_MASK_EN
      SREG_SIM: SRRD = DBITS'(sim_q);
`endif
      SREG_SR0: SRRD = sr0_q;
      SREG_SR1: SRRD = sr1_q;
      default:  SRRD = DBITS'(SREG_FILL);
    endcase
  end

  assign IRQ     = irq_q;
  assign HANDLER = sih_q;
  assign RETI_PC = sra_q;
  assign SCS     = scs_q;

endmodule

// File: tb/tb_intr_ctl.sv
// Directed bench for intr_ctl: reset values, entry/return sequencing, holdoff, WSR races.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Define INTR_MASK_EN to also exercise the per-source mask register.
module tb_intr_ctl;

  logic        CLK = 1'b0;
  logic        INIT;
  logic [2:0]  INTR;
  logic        IRQ;
  logic        IRQ_ACK;
  logic [15:0] RET_PC;
  logic [15:0] HANDLER;
  logic        RETI;
  logic [15:0] RETI_PC;
  logic [2:0]  SRNO;
  logic [15:0] SRRD;
  logic        SRWE;
  logic [15:0] SRWD;
  logic [3:0]  SCS;

  int total = 0;
  int bad   = 0;

  intr_ctl dut (
    .CLK     (CLK),
    .INIT    (INIT),
    .INTR    (INTR),
    .IRQ     (IRQ),
    .IRQ_ACK (IRQ_ACK),
    .RET_PC  (RET_PC),
    .HANDLER (HANDLER),
    .RETI    (RETI),
    .RETI_PC (RETI_PC),
    .SRNO    (SRNO),
    .SRRD    (SRRD),
    .SRWE    (SRWE),
    .SRWD    (SRWD),
    .SCS     (SCS)
  );

  always #5 CLK = ~CLK;

`ifdef INTR_MASK_EN
  localparam logic [15:0] REG4_RST = 16'h0007;
`else
  localparam logic [15:0] REG4_RST = 16'hFAFA;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [2:0] n, input logic [15:0] exp, input string tag);
    SRNO = n;
    #1;
    check(tag, 32'(SRRD), 32'(exp));
  endtask

  task automatic wsr(input logic [2:0] n, input logic [15:0] d);
    SRNO = n;
    SRWD = d;
    SRWE = 1'b1;
    tick();
    SRWE = 1'b0;
  endtask

  task automatic wait_irq(input int maxc, input string tag);
    int n = 0;
    while (!IRQ && n < maxc) begin
      tick();
      n++;
    end
    check(tag, 32'(IRQ), 32'd1);
  endtask

  task automatic ack(input logic [15:0] pc);
    IRQ_ACK = 1'b1;
    RET_PC  = pc;
    tick();
    IRQ_ACK = 1'b0;
  endtask

  initial begin
    INIT = 1'b1; INTR = '0; IRQ_ACK = 1'b0; RET_PC = '0; RETI = 1'b0;
    SRNO = '0; SRWE = 1'b0; SRWD = '0;
    tick();
    tick();
    INIT = 1'b0;

    // Reset values
    check("rst_irq", 32'(IRQ), 32'd0);
    check("rst_handler", 32'(HANDLER), 32'h0010);
    check("rst_reti_pc", 32'(RETI_PC), 32'h0000);
    check("rst_scs", 32'(SCS), 32'h0);
    rd(3'd1, 16'h0010, "rst_rd_sih");
    rd(3'd0, 16'h0000, "rst_rd_scs");
    rd(3'd4, REG4_RST, "rst_rd_reg4");
    rd(3'd5, 16'hFAFA, "rst_rd_reg5");

    // Entry: IE=1, sources 1 and 2 active -> source 1 wins
    wsr(3'd0, 16'h0001);
    check("scs_ie_set", 32'(SCS), 32'h1);
    INTR = 3'b110;
    #1;
    check("irq_not_yet", 32'(IRQ), 32'd0);
    tick();
    check("irq_one_cycle", 32'(IRQ), 32'd1);
    INTR = 3'b000;
    tick();
    check("irq_held_pend", 32'(IRQ), 32'd1);
    ack(16'h0240);
    check("entry_sra", 32'(RETI_PC), 32'h0240);
    rd(3'd3, 16'h0001, "entry_sii");
    check("entry_scs", 32'(SCS), 32'h6);
    check("entry_irq_low", 32'(IRQ), 32'd0);
    INTR = 3'b001;
    tick();
    tick();
    check("ie0_blocks", 32'(IRQ), 32'd0);

    // Return: IE/CM restored, then HOLDOFF cycles of HOLD, one IDLE arbitration cycle, then PEND
    RETI = 1'b1;
    tick();
    RETI = 1'b0;
    check("reti_scs", 32'(SCS), 32'h3);
    check("hold_irq0", 32'(IRQ), 32'd0);
    tick();
    check("hold_irq1", 32'(IRQ), 32'd0);
    tick();
    check("hold_idle_irq", 32'(IRQ), 32'd0);
    tick();
    check("irq_after_holdoff", 32'(IRQ), 32'd1);
    ack(16'h0300);
    rd(3'd3, 16'h0000, "hold_sii");
    check("hold_sra", 32'(RETI_PC), 32'h0300);

    // WSR clearing IE while pending withdraws the request
    RETI = 1'b1;
    tick();
    RETI = 1'b0;
    wait_irq(8, "pend2_irq");
    wsr(3'd0, 16'h0000);
    check("wsr_clr_irq", 32'(IRQ), 32'd0);
    check("wsr_clr_scs", 32'(SCS), 32'h0);
    check("wsr_clr_sra", 32'(RETI_PC), 32'h0300);
    tick();
    check("wsr_clr_stay", 32'(IRQ), 32'd0);

    // Ack and RETI together; a WSR to SR0 proceeds alongside
    wsr(3'd0, 16'h0001);
    wait_irq(4, "pend3_irq");
    $display("note: IRQ_ACK and RETI driven together (protocol violation stimulus)");
    IRQ_ACK = 1'b1; RETI = 1'b1; RET_PC = 16'h0400;
    SRNO = 3'd6; SRWD = 16'hBEEF; SRWE = 1'b1;
    tick();
    IRQ_ACK = 1'b0; RETI = 1'b0; SRWE = 1'b0;
    check("race_scs", 32'(SCS), 32'h6);
    check("race_sra", 32'(RETI_PC), 32'h0400);
    rd(3'd3, 16'h0000, "race_sii");
    rd(3'd6, 16'hBEEF, "race_sr0");
    tick();
    check("race_irq_low", 32'(IRQ), 32'd0);

    // Plain register file behaviour
    INTR = 3'b000;
    wsr(3'd1, 16'h0080);
    check("sih_write", 32'(HANDLER), 32'h0080);
    wsr(3'd7, 16'h1234);
    rd(3'd7, 16'h1234, "sr1_write");
    wsr(3'd5, 16'hFFFF);
    rd(3'd5, 16'hFAFA, "reg5_ignored");
    wsr(3'd0, 16'hFFF5);
    rd(3'd0, 16'h0005, "scs_4bit");
    wsr(3'd0, 16'h0000);
`ifndef INTR_MASK_EN
    wsr(3'd4, 16'h0000);
    rd(3'd4, 16'hFAFA, "reg4_ignored");
`endif

    // Lowest-priority source, optionally gated by the mask
    wsr(3'd0, 16'h0001);
`ifdef INTR_MASK_EN
    wsr(3'd4, 16'h0003);
    rd(3'd4, 16'h0003, "sim_rd");
    INTR = 3'b100;
    tick();
    tick();
    tick();
    check("masked_no_irq", 32'(IRQ), 32'd0);
    wsr(3'd4, 16'h0007);
`else
    INTR = 3'b100;
`endif
    wait_irq(4, "src2_irq");
    ack(16'h0500);
    rd(3'd3, 16'h0002, "src2_sii");

    // Reset while pending
    RETI = 1'b1;
    tick();
    RETI = 1'b0;
    wait_irq(8, "pend4_irq");
    INIT = 1'b1;
    tick();
    INIT = 1'b0;
    check("rst2_irq", 32'(IRQ), 32'd0);
    check("rst2_scs", 32'(SCS), 32'h0);
    check("rst2_handler", 32'(HANDLER), 32'h0010);
    check("rst2_reti_pc", 32'(RETI_PC), 32'h0000);
    rd(3'd4, REG4_RST, "rst2_reg4");
    tick();
    check("rst2_stay", 32'(IRQ), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
